// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler.
//   - movement bit indices (ES..SL), used for the sensor and lamp vectors
//   - phase_t: the eight compatible movement pairs
//   - phase_state_t: GREEN / YELLOW / ALLRED
//   - phase_mask(): movement pair served by a phase, as an 8-bit vector
package traffic_pkg;

    localparam int unsigned NUM_MOV = 8;

    localparam int unsigned MOV_ES = 0;
    localparam int unsigned MOV_EL = 1;
    localparam int unsigned MOV_WS = 2;
    localparam int unsigned MOV_WL = 3;
    localparam int unsigned MOV_NS = 4;
    localparam int unsigned MOV_NL = 5;
    localparam int unsigned MOV_SS = 6;
    localparam int unsigned MOV_SL = 7;

    typedef enum logic [2:0] {
        PH_ELWL = 3'd0,
        PH_ESEL = 3'd1,
        PH_ESWS = 3'd2,
        PH_WSWL = 3'd3,
        PH_NLSL = 3'd4,
        PH_NSNL = 3'd5,
        PH_NSSS = 3'd6,
        PH_SSSL = 3'd7
    } phase_t;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } phase_state_t;

    function automatic logic [NUM_MOV-1:0] phase_mask(input phase_t p);
        logic [NUM_MOV-1:0] m;
        m = '0;
        case (p)
            PH_ELWL: m = (8'd1 << MOV_EL) | (8'd1 << MOV_WL);
            PH_ESEL: m = (8'd1 << MOV_ES) | (8'd1 << MOV_EL);
            PH_ESWS: m = (8'd1 << MOV_ES) | (8'd1 << MOV_WS);
            PH_WSWL: m = (8'd1 << MOV_WS) | (8'd1 << MOV_WL);
            PH_NLSL: m = (8'd1 << MOV_NL) | (8'd1 << MOV_SL);
            PH_NSNL: m = (8'd1 << MOV_NS) | (8'd1 << MOV_NL);
            PH_NSSS: m = (8'd1 << MOV_NS) | (8'd1 << MOV_SS);
            PH_SSSL: m = (8'd1 << MOV_SS) | (8'd1 << MOV_SL);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/traffic_phase_select.sv
// Round-robin next-phase selector (purely combinational).
//   pending    in  8  latched per-movement demand
//   phase      in  3  phase currently being served
//   next_phase out 3  phase to load when all-red ends
// Scans phase+1 .. phase+8 (mod 8), so the current phase is the last
// candidate. A phase with both movements pending beats one with a single
// movement pending; with no demand at all the rest phase is chosen.
module traffic_phase_select
    import traffic_pkg::*;
#(
    parameter int unsigned DEFAULT_PHASE = 1
) (
    input  logic [7:0] pending,
    input  phase_t     phase,
    output phase_t     next_phase
);

    phase_t     cand;
    phase_t     first_both;
    phase_t     first_any;
    logic       found_both;
    logic       found_any;
    logic [7:0] cand_mask;

    // One table-driven scan shared by every phase instead of a per-phase
    // transition list.
    always_comb begin
        cand       = phase;
        cand_mask  = '0;
        first_both = phase;
        first_any  = phase;
        found_both = 1'b0;
        found_any  = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            cand      = phase_t'(phase + 3'(i));
            cand_mask = phase_mask(cand);
            if (!found_both && ((pending & cand_mask) == cand_mask)) begin
                found_both = 1'b1;
                first_both = cand;
            end
            if (!found_any && ((pending & cand_mask) != '0)) begin
                found_any = 1'b1;
                first_any = cand;
            end
        end
        if (found_both) begin
            next_phase = first_both;
        end else if (found_any) begin
            next_phase = first_any;
        end else begin
            next_phase = phase_t'(3'(DEFAULT_PHASE));
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Eight-movement intersection phase scheduler.
//   clk_in      in   1  clock, rising edge
//   reset       in   1  synchronous, active-low
//   sensor      in   8  per-movement detector (0 ES,1 EL,2 WS,3 WL,4 NS,5 NL,6 SS,7 SL)
//   green       out  8  per-movement green lamp
//   yellow      out  8  per-movement yellow lamp
//   red         out  8  ~(green | yellow)
//   phase       out  3  phase index being served
//   phase_state out  2  0 GREEN, 1 YELLOW, 2 ALLRED
//   pending     out  8  latched demand
// Green runs min-green / gap-out / max-green and rests indefinitely when no
// conflicting demand exists; every change passes yellow then all-red.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned CTR_W         = 8,
    parameter int unsigned MIN_GREEN     = 5,
    parameter int unsigned GAP           = 3,
    parameter int unsigned MAX_GREEN     = 10,
    parameter int unsigned YELLOW_T      = 2,
    parameter int unsigned ALLRED_T      = 1,
    parameter int unsigned DEFAULT_PHASE = 1
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [7:0] sensor,
    output logic [7:0] green,
    output logic [7:0] yellow,
    output logic [7:0] red,
    output logic [2:0] phase,
    output logic [1:0] phase_state,
    output logic [7:0] pending
);

    localparam phase_t RESET_PHASE = phase_t'(3'(DEFAULT_PHASE));

    phase_state_t     state_q, state_d;
    phase_t           phase_q, phase_d, sel_phase;
    logic [CTR_W-1:0] green_ctr_q, green_ctr_d;
    logic [CTR_W-1:0] gap_ctr_q, gap_ctr_d;
    logic [CTR_W-1:0] phase_ctr_q, phase_ctr_d;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       served;
    logic [7:0]       green_lamps;
    logic [7:0]       yellow_lamps;
    logic             conflict;
    logic             terminate;

    function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
        return (v == '1) ? v : v + CTR_W'(1);
    endfunction

    traffic_phase_select #(
        .DEFAULT_PHASE(DEFAULT_PHASE)
    ) u_select (
        .pending   (pending_q),
        .phase     (phase_q),
        .next_phase(sel_phase)
    );

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= ST_GREEN;
            phase_q     <= RESET_PHASE;
            green_ctr_q <= '0;
            gap_ctr_q   <= '0;
            phase_ctr_q <= '0;
            pending_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            green_ctr_q <= green_ctr_d;
            gap_ctr_q   <= gap_ctr_d;
            phase_ctr_q <= phase_ctr_d;
            pending_q   <= pending_d;
        end
    end

    always_comb begin
        served    = phase_mask(phase_q);
        conflict  = |(pending_q & ~served);
        terminate = (green_ctr_q >= CTR_W'(MIN_GREEN - 1)) && conflict &&
                    ((gap_ctr_q >= CTR_W'(GAP - 1)) ||
                     (green_ctr_q >= CTR_W'(MAX_GREEN - 1)));

        state_d     = state_q;
        phase_d     = phase_q;
        green_ctr_d = green_ctr_q;
        gap_ctr_d   = gap_ctr_q;
        phase_ctr_d = phase_ctr_q;
        // A lit green clears its demand and also masks any new set.
        pending_d   = (pending_q | sensor) & ~green_lamps;

        case (state_q)
            ST_GREEN: begin
                green_ctr_d = sat_inc(green_ctr_q);
                gap_ctr_d   = ((sensor & served) != '0) ? '0 : sat_inc(gap_ctr_q);
                if (terminate) begin
                    state_d     = ST_YELLOW;
                    phase_ctr_d = '0;
                end
            end
            ST_YELLOW: begin
                if (phase_ctr_q == CTR_W'(YELLOW_T - 1)) begin
                    state_d     = ST_ALLRED;
                    phase_ctr_d = '0;
                end else begin
                    phase_ctr_d = phase_ctr_q + CTR_W'(1);
                end
            end
            ST_ALLRED: begin
                if (phase_ctr_q == CTR_W'(ALLRED_T - 1)) begin
                    state_d     = ST_GREEN;
                    phase_d     = sel_phase;
                    green_ctr_d = '0;
                    gap_ctr_d   = '0;
                    phase_ctr_d = '0;
                end else begin
                    phase_ctr_d = phase_ctr_q + CTR_W'(1);
                end
            end
            default: begin
                state_d = ST_GREEN;
                phase_d = RESET_PHASE;
            end
        endcase
    end

    always_comb begin
        green_lamps  = '0;
        yellow_lamps = '0;
        case (state_q)
            ST_GREEN:  green_lamps  = phase_mask(phase_q);
            ST_YELLOW: yellow_lamps = phase_mask(phase_q);
            default:   ;
        endcase
        green       = green_lamps;
        yellow      = yellow_lamps;
        red         = ~(green_lamps | yellow_lamps);
        phase       = phase_q;
        phase_state = state_q;
        pending     = pending_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler. "Cycle c" of a test is
// the clock period following the c-th rising edge after the reset edge;
// inputs driven in cycle c are sampled at the edge that ends it.
module tb_traffic_phase_scheduler;

    localparam int unsigned YELLOW_T = 2;
    localparam int unsigned ALLRED_T = 1;

    localparam int K_GREEN  = 0;
    localparam int K_YELLOW = 1;
    localparam int K_RED    = 2;
    localparam int K_PHASE  = 3;
    localparam int K_STATE  = 4;
    localparam int K_PEND   = 5;

    // Movement pair lit by each phase index (bit 0 ES .. bit 7 SL).
    localparam logic [7:0] TB_MASK [8] = '{8'h0A, 8'h03, 8'h05, 8'h0C,
                                           8'hA0, 8'h30, 8'h50, 8'hC0};

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t  sb [$];
    string kname [6] = '{"green", "yellow", "red", "phase", "phase_state", "pending"};

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] sensor = '0;
    logic [7:0] green, yellow, red, pending;
    logic [2:0] phase;
    logic [1:0] phase_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_in = ~clk_in;

    traffic_phase_scheduler #(
        .CTR_W        (8),
        .MIN_GREEN    (5),
        .GAP          (3),
        .MAX_GREEN    (10),
        .YELLOW_T     (YELLOW_T),
        .ALLRED_T     (ALLRED_T),
        .DEFAULT_PHASE(1)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .sensor     (sensor),
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .phase      (phase),
        .phase_state(phase_state),
        .pending    (pending)
    );

    // Lamp consistency: only the served pair is lit, in the colour of the state.
    logic       lamp_ok;
    logic [7:0] exp_g, exp_y;
    always_comb begin
        exp_g   = (phase_state == 2'd0) ? TB_MASK[phase] : 8'h00;
        exp_y   = (phase_state == 2'd1) ? TB_MASK[phase] : 8'h00;
        lamp_ok = (green === exp_g) && (yellow === exp_y) && (red === ~(green | yellow))
                  && (phase_state !== 2'd3);
    end

    // Sequence tracker: green -> YELLOW_T yellow -> ALLRED_T all-red -> green,
    // and the phase index only changes when all-red hands over to green.
    logic [1:0] prev_ps    = 2'd0;
    logic [2:0] prev_phase = 3'd0;
    int         run        = 0;
    logic       seq_ok     = 1'b1;
    logic       seq_v;
    always @(negedge clk_in) begin
        if (!reset) begin
            prev_ps    <= 2'd0;
            prev_phase <= phase;
            run        <= 0;
            seq_ok     <= 1'b1;
        end else begin
            seq_v = 1'b1;
            case (phase_state)
                2'd0: if (prev_ps == 2'd1 || (prev_ps == 2'd2 && run != ALLRED_T)) seq_v = 1'b0;
                2'd1: if (prev_ps == 2'd2 || (prev_ps == 2'd1 && run >= YELLOW_T)) seq_v = 1'b0;
                2'd2: if (prev_ps == 2'd0 || (prev_ps == 2'd1 && run != YELLOW_T) ||
                          (prev_ps == 2'd2 && run >= ALLRED_T)) seq_v = 1'b0;
                default: seq_v = 1'b0;
            endcase
            if (phase != prev_phase && !(phase_state == 2'd0 && prev_ps == 2'd2)) seq_v = 1'b0;
            run        <= (phase_state == prev_ps) ? run + 1 : 1;
            prev_ps    <= phase_state;
            prev_phase <= phase;
            seq_ok     <= seq_v;
        end
    end

    function automatic logic [7:0] observe(input int k);
        case (k)
            K_GREEN:  return green;
            K_YELLOW: return yellow;
            K_RED:    return red;
            K_PHASE:  return {5'b0, phase};
            K_STATE:  return {6'b0, phase_state};
            default:  return pending;
        endcase
    endfunction

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    // Leaves the bench in cycle 0 with reset released.
    task automatic do_reset();
        reset  = 1'b0;
        sensor = '0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        for (int c = 0; c < 50; c++) begin
            if (c == 0) begin
                sb.push_back('{c, K_RED, 8'hFC});
                sb.push_back('{c, K_YELLOW, 8'h00});
                sb.push_back('{c, K_PEND, 8'h00});
            end
            sb.push_back('{c, K_GREEN, 8'h03});
            sb.push_back('{c, K_PHASE, 8'h01});
            sb.push_back('{c, K_STATE, 8'h00});
        end
        for (int c = 0; c < 50; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_cmp++;
                if (observe(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL reset_idle %s @cyc %0d: got %h expected %h", kname[e.kind], c, observe(e.kind), e.val);
                end
            end
            n_cmp++;
            if (!(lamp_ok === 1'b1 && seq_ok === 1'b1)) begin
                n_bad++;
                $display("FAIL reset_idle invariant @cyc %0d: lamp_ok=%b seq_ok=%b expected 1 1", c, lamp_ok, seq_ok);
            end
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL reset_idle leftover: %0d unconsumed expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_gap_out();
        exp_t e;
        do_reset();
        sb.push_back('{1, K_PEND, 8'h10});
        sb.push_back('{4, K_STATE, 8'h00});
        sb.push_back('{5, K_STATE, 8'h01});
        sb.push_back('{5, K_YELLOW, 8'h03});
        sb.push_back('{6, K_YELLOW, 8'h03});
        sb.push_back('{7, K_STATE, 8'h02});
        sb.push_back('{7, K_RED, 8'hFF});
        sb.push_back('{8, K_PHASE, 8'h05});
        sb.push_back('{8, K_GREEN, 8'h30});
        sb.push_back('{8, K_PEND, 8'h10});
        sb.push_back('{9, K_PEND, 8'h00});
        sensor = 8'h10;
        for (int c = 0; c < 12; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_cmp++;
                if (observe(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL gap_out %s @cyc %0d: got %h expected %h", kname[e.kind], c, observe(e.kind), e.val);
                end
            end
            n_cmp++;
            if (!(lamp_ok === 1'b1 && seq_ok === 1'b1)) begin
                n_bad++;
                $display("FAIL gap_out invariant @cyc %0d: lamp_ok=%b seq_ok=%b expected 1 1", c, lamp_ok, seq_ok);
            end
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL gap_out leftover: %0d unconsumed expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_max_green();
        exp_t e;
        do_reset();
        sb.push_back('{4, K_STATE, 8'h00});
        sb.push_back('{8, K_STATE, 8'h00});
        sb.push_back('{9, K_STATE, 8'h00});
        sb.push_back('{9, K_PEND, 8'h10});
        sb.push_back('{10, K_STATE, 8'h01});
        sb.push_back('{10, K_YELLOW, 8'h03});
        sb.push_back('{11, K_YELLOW, 8'h03});
        sb.push_back('{11, K_PEND, 8'h10});
        sb.push_back('{12, K_STATE, 8'h02});
        sb.push_back('{12, K_RED, 8'hFF});
        sb.push_back('{13, K_PHASE, 8'h05});
        sb.push_back('{13, K_GREEN, 8'h30});
        sensor = 8'h11;
        for (int c = 0; c < 15; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_cmp++;
                if (observe(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL max_green %s @cyc %0d: got %h expected %h", kname[e.kind], c, observe(e.kind), e.val);
                end
            end
            n_cmp++;
            if (!(lamp_ok === 1'b1 && seq_ok === 1'b1)) begin
                n_bad++;
                $display("FAIL max_green invariant @cyc %0d: lamp_ok=%b seq_ok=%b expected 1 1", c, lamp_ok, seq_ok);
            end
            // ES drops once its green ends so it does not re-latch demand.
            if (c == 10) sensor = 8'h10;
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL max_green leftover: %0d unconsumed expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_pair_select();
        exp_t e;
        do_reset();
        sb.push_back('{20, K_PHASE, 8'h01});
        sb.push_back('{21, K_PEND, 8'h50});
        sb.push_back('{21, K_STATE, 8'h00});
        sb.push_back('{22, K_STATE, 8'h01});
        sb.push_back('{24, K_STATE, 8'h02});
        sb.push_back('{25, K_PHASE, 8'h06});
        sb.push_back('{25, K_GREEN, 8'h50});
        sb.push_back('{26, K_PEND, 8'h00});
        for (int c = 0; c < 28; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_cmp++;
                if (observe(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL pair_select %s @cyc %0d: got %h expected %h", kname[e.kind], c, observe(e.kind), e.val);
                end
            end
            n_cmp++;
            if (!(lamp_ok === 1'b1 && seq_ok === 1'b1)) begin
                n_bad++;
                $display("FAIL pair_select invariant @cyc %0d: lamp_ok=%b seq_ok=%b expected 1 1", c, lamp_ok, seq_ok);
            end
            sensor = (c == 20) ? 8'h50 : 8'h00;
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL pair_select leftover: %0d unconsumed expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        do_reset();
        sb.push_back('{21, K_PEND, 8'h08});
        sb.push_back('{22, K_STATE, 8'h01});
        sb.push_back('{25, K_PHASE, 8'h03});
        sb.push_back('{25, K_GREEN, 8'h0C});
        sb.push_back('{25, K_YELLOW, 8'h00});
        sb.push_back('{26, K_PEND, 8'h00});
        for (int c = 0; c < 28; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_cmp++;
                if (observe(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL rotation %s @cyc %0d: got %h expected %h", kname[e.kind], c, observe(e.kind), e.val);
                end
            end
            n_cmp++;
            if (!(lamp_ok === 1'b1 && seq_ok === 1'b1)) begin
                n_bad++;
                $display("FAIL rotation invariant @cyc %0d: lamp_ok=%b seq_ok=%b expected 1 1", c, lamp_ok, seq_ok);
            end
            sensor = (c == 20) ? 8'h08 : 8'h00;
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL rotation leftover: %0d unconsumed expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_in_yellow();
        exp_t e;
        do_reset();
        sb.push_back('{5, K_STATE, 8'h01});
        sb.push_back('{5, K_YELLOW, 8'h03});
        sb.push_back('{5, K_PEND, 8'h10});
        sb.push_back('{6, K_PHASE, 8'h01});
        sb.push_back('{6, K_GREEN, 8'h03});
        sb.push_back('{6, K_STATE, 8'h00});
        sb.push_back('{6, K_YELLOW, 8'h00});
        sb.push_back('{6, K_PEND, 8'h00});
        sb.push_back('{7, K_PEND, 8'h10});
        sensor = 8'h10;
        for (int c = 0; c < 10; c++) begin
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                n_cmp++;
                if (observe(e.kind) !== e.val) begin
                    n_bad++;
                    $display("FAIL reset_in_yellow %s @cyc %0d: got %h expected %h", kname[e.kind], c, observe(e.kind), e.val);
                end
            end
            n_cmp++;
            if (!(lamp_ok === 1'b1 && seq_ok === 1'b1)) begin
                n_bad++;
                $display("FAIL reset_in_yellow invariant @cyc %0d: lamp_ok=%b seq_ok=%b expected 1 1", c, lamp_ok, seq_ok);
            end
            if (c == 5) reset = 1'b0;
            if (c == 6) reset = 1'b1;
            step();
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL reset_in_yellow leftover: %0d unconsumed expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_gap_out();
        test_max_green();
        test_pair_select();
        test_rotation();
        test_reset_in_yellow();
        sensor = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
